ksa_swap_fsm: RTL and testbench

- Performs the RC4 key-scheduling shuffle over the 256-byte S memory once init_ram_fsm has loaded S[i]=i.
- Whereas init_ram_fsm only writes the memory, this block reads it back, computes j, and swaps S[i]/S[j] for i=0..255.
- Single master of the s_memory port while busy.
- Pulses fin_strobe when done so the PRGA stage can start.

---
 rtl/ksa_swap_fsm.sv | 158 +++++++++++++++
 tb/tb_ksa_swap_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm
//   RC4 key-scheduling shuffle over a 256-byte S memory that has already
//   been loaded with S[i]=i. For i = 0..255 it reads S[i], forms
//   j = j + S[i] + key[i mod KEY_LEN], reads S[j] and writes the two bytes
//   back swapped. While busy it is the only master of the s_memory port.
//   When the shuffle is complete it pulses fin_strobe for one cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a shuffle (sampled only when idle)
//   key        secret key, byte 0 in the most significant byte
//   addr       s_memory address
//   wr_data    s_memory write data
//   wren       s_memory write enable
//   rd_data    s_memory read data (synchronous RAM, one cycle after addr)
//   busy       high for the whole read/compute/swap sequence
//   fin_strobe one-cycle completion pulse
module ksa_swap_fsm #(
    parameter int unsigned KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_LEN-1:0]   key,
    output logic [7:0]             addr,
    output logic [7:0]             wr_data,
    output logic                   wren,
    input  logic [7:0]             rd_data,
    output logic                   busy,
    output logic                   fin_strobe
);

    localparam int unsigned KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        RD_SJ,
        WAIT_SJ,
        WR_SI,
        WR_SJ,
        DONE
    } state_t;

    state_t               state;
    logic [7:0]           i;
    logic [7:0]           j;
    logic [KW-1:0]        k;
    logic [7:0]           si;
    logic [7:0]           sj;
    logic [8*KEY_LEN-1:0] key_q;
    logic [7:0]           key_byte;
    logic [7:0]           j_next;

    // Select key byte k without a divider; byte 0 sits in the top byte.
    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < KEY_LEN; b++) begin
            if (k == KW'(b)) begin
                key_byte = key_q[8*(KEY_LEN-1-b) +: 8];
            end
        end
    end

    assign j_next = j + rd_data + key_byte;

    // Outputs are registered: each branch loads the values the next state
    // presents, so addr for RD_SJ already carries the updated j.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            si         <= '0;
            sj         <= '0;
            key_q      <= '0;
            addr       <= '0;
            wr_data    <= '0;
            wren       <= 1'b0;
            busy       <= 1'b0;
            fin_strobe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr       <= '0;
                    wr_data    <= '0;
                    wren       <= 1'b0;
                    busy       <= 1'b0;
                    fin_strobe <= 1'b0;
                    if (start) begin
                        key_q <= key;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        addr  <= '0;
                        busy  <= 1'b1;
                        state <= RD_SI;
                    end
                end
                RD_SI: begin
                    state <= WAIT_SI;
                end
                WAIT_SI: begin
                    si    <= rd_data;
                    j     <= j_next;
                    addr  <= j_next;
                    state <= RD_SJ;
                end
                RD_SJ: begin
                    state <= WAIT_SJ;
                end
                WAIT_SJ: begin
                    sj      <= rd_data;
                    addr    <= i;
                    wr_data <= rd_data;
                    wren    <= 1'b1;
                    state   <= WR_SI;
                end
                WR_SI: begin
                    addr    <= j;
                    wr_data <= si;
                    wren    <= 1'b1;
                    state   <= WR_SJ;
                end
                WR_SJ: begin
                    wren    <= 1'b0;
                    wr_data <= '0;
                    if (i == 8'd255) begin
                        addr       <= '0;
                        busy       <= 1'b0;
                        fin_strobe <= 1'b1;
                        state      <= DONE;
                    end else begin
                        i     <= i + 8'd1;
                        k     <= (k == KW'(KEY_LEN-1)) ? '0 : k + KW'(1);
                        addr  <= i + 8'd1;
                        state <= RD_SI;
                    end
                end
                DONE: begin
                    fin_strobe <= 1'b0;
                    busy       <= 1'b0;
                    wren       <= 1'b0;
                    addr       <= '0;
                    wr_data    <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
module tb_ksa_swap_fsm;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic [23:0] key_a;
    logic [15:0] key_b;
    logic [7:0]  addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;
    logic        wren_a, busy_a, fin_a, wren_b, busy_b, fin_b;
    logic        init_a, init_b;

    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];

    ksa_swap_fsm #(.KEY_LEN(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key(key_a),
        .addr(addr_a), .wr_data(wd_a), .wren(wren_a), .rd_data(rd_a),
        .busy(busy_a), .fin_strobe(fin_a)
    );

    ksa_swap_fsm #(.KEY_LEN(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key_b),
        .addr(addr_b), .wr_data(wd_b), .wren(wren_b), .rd_data(rd_b),
        .busy(busy_b), .fin_strobe(fin_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs; contents untouched by reset.
    always @(posedge clk) begin
        if (init_a) begin
            for (int n = 0; n < 256; n++) mem_a[n] <= 8'(n);
        end else if (wren_a) begin
            mem_a[addr_a] <= wd_a;
        end
        rd_a <= mem_a[addr_a];
    end

    always @(posedge clk) begin
        if (init_b) begin
            for (int n = 0; n < 256; n++) mem_b[n] <= 8'(n);
        end else if (wren_b) begin
            mem_b[addr_b] <= wd_b;
        end
        rd_b <= mem_b[addr_b];
    end

    // Probe of whichever instance the current run targets.
    bit         sel;
    logic [7:0] addr_s, wd_s;
    logic       wren_s, busy_s, fin_s;
    assign addr_s = sel ? addr_b : addr_a;
    assign wd_s   = sel ? wd_b   : wd_a;
    assign wren_s = sel ? wren_b : wren_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign fin_s  = sel ? fin_b  : fin_a;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wlog[$];
    wr_t        exp_w[$];
    logic [7:0] snap[256];
    logic [7:0] final_mem[256];
    logic [7:0] model_mem[256];
    logic [7:0] prev_mem[256];

    int unsigned n_cmp;
    int unsigned n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic init_mem(input bit s);
        @(negedge clk);
        if (s) init_b = 1'b1; else init_a = 1'b1;
        @(negedge clk);
        init_a = 1'b0;
        init_b = 1'b0;
    endtask

    // Plain RC4 key schedule on a copy of the starting memory; also lists
    // the byte writes expected on the bus in order.
    task automatic ref_model(input bit s, input logic [23:0] k);
        logic [7:0]  S[256];
        logic [7:0]  kb, tmp;
        int unsigned jj, kl;
        kl = s ? 2 : 3;
        S  = snap;
        jj = 0;
        exp_w.delete();
        for (int ii = 0; ii < 256; ii++) begin
            kb = k[8*(kl-1-(ii % kl)) +: 8];
            jj = (jj + S[ii] + kb) % 256;
            exp_w.push_back('{8'(ii), S[jj]});
            exp_w.push_back('{8'(jj), S[ii]});
            tmp    = S[ii];
            S[ii]  = S[jj];
            S[jj]  = tmp;
        end
        model_mem = S;
    endtask

    // mode 0: start pulsed; 1: start toggled and key changed mid-run;
    // 2: start held high. rst_at != 0 asserts reset in that cycle.
    task automatic run(input bit s, input logic [23:0] k, input int unsigned mode,
                       input int unsigned rst_at);
        int unsigned busy_cnt, first_busy, last_busy, fin_cnt, fin_cyc, wr_cnt, rerun;
        int unsigned errs;
        int unsigned seen[256];
        busy_cnt = 0; first_busy = 0; last_busy = 0;
        fin_cnt = 0; fin_cyc = 0; wr_cnt = 0; rerun = 0;
        sel = s;
        for (int n = 0; n < 256; n++) snap[n] = s ? mem_b[n] : mem_a[n];
        wlog.delete();
        if (s) begin key_b = k[15:0]; start_b = 1'b1; end
        else   begin key_a = k;       start_a = 1'b1; end
        @(negedge clk);
        for (int n = 1; n <= 1545; n++) begin
            if (n <= 1537) begin
                if (busy_s) begin
                    busy_cnt++;
                    if (first_busy == 0) first_busy = n;
                    last_busy = n;
                end
                if (wren_s) begin
                    wr_cnt++;
                    wlog.push_back('{addr_s, wd_s});
                end
            end else if (busy_s && rerun == 0) begin
                rerun = n;
            end
            if (fin_s) begin fin_cnt++; fin_cyc = n; end
            if (n == 1538) begin
                for (int m = 0; m < 256; m++) final_mem[m] = s ? mem_b[m] : mem_a[m];
            end
            if (n == 1 && mode != 2) begin start_a = 1'b0; start_b = 1'b0; end
            if (mode == 1 && n >= 100 && n < 140) begin
                if (s) begin start_b = 1'($urandom_range(0, 1)); key_b = 16'($urandom); end
                else   begin start_a = 1'($urandom_range(0, 1)); key_a = 24'($urandom); end
            end
            if (mode == 1 && n == 140) begin start_a = 1'b0; start_b = 1'b0; end
            if (rst_at != 0 && n == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_async_addr", 32'(addr_s), 32'd0);
                check("rst_async_wdata", 32'(wd_s), 32'd0);
                check("rst_async_wren", 32'(wren_s), 32'd0);
                check("rst_async_busy", 32'(busy_s), 32'd0);
                check("rst_async_fin", 32'(fin_s), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_idle_busy", 32'(busy_s), 32'd0);
                check("rst_idle_wren", 32'(wren_s), 32'd0);
                break;
            end
            @(negedge clk);
        end
        if (rst_at == 0) begin
            if (mode == 2) begin
                start_a = 1'b0; start_b = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
            end
            ref_model(s, k);
            check("busy_first", first_busy, 1);
            check("busy_cycles", busy_cnt, 1536);
            check("busy_last", last_busy, 1536);
            check("fin_count", fin_cnt, 1);
            check("fin_cycle", fin_cyc, 1537);
            check("wren_count", wr_cnt, 512);
            errs = 0;
            for (int m = 0; m < 512; m++) begin
                if (m >= wlog.size()) errs++;
                else if (wlog[m].a !== exp_w[m].a || wlog[m].d !== exp_w[m].d) errs++;
            end
            check("write_seq_errs", errs, 0);
            errs = 0;
            for (int m = 0; m < 256; m++) begin
                if (final_mem[m] !== model_mem[m]) errs++;
                seen[m] = 0;
            end
            check("final_mem_errs", errs, 0);
            for (int m = 0; m < 256; m++) seen[final_mem[m]]++;
            errs = 0;
            for (int m = 0; m < 256; m++) if (seen[m] != 1) errs++;
            check("permutation_errs", errs, 0);
            check("restart_cycle", rerun, (mode == 2) ? fin_cyc + 2 : 0);
        end
    endtask

    typedef struct {
        bit          s;
        logic [23:0] key;
        int unsigned widx;
        logic [7:0]  a;
        logic [7:0]  d;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int unsigned errs;
        n_cmp = 0; n_bad = 0;
        sel = 1'b0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        key_a = '0; key_b = '0; init_a = 1'b0; init_b = 1'b0;

        vecs[0]  = '{1'b0, 24'h000000, 0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 24'h000000, 1, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 24'h000000, 2, 8'h01, 8'h01};
        vecs[3]  = '{1'b0, 24'h000000, 3, 8'h01, 8'h01};
        vecs[4]  = '{1'b0, 24'h000000, 4, 8'h02, 8'h03};
        vecs[5]  = '{1'b0, 24'h000000, 5, 8'h03, 8'h02};
        vecs[6]  = '{1'b0, 24'h010203, 0, 8'h00, 8'h01};
        vecs[7]  = '{1'b0, 24'h010203, 1, 8'h01, 8'h00};
        vecs[8]  = '{1'b0, 24'h010203, 2, 8'h01, 8'h03};
        vecs[9]  = '{1'b0, 24'h010203, 3, 8'h03, 8'h00};
        vecs[10] = '{1'b1, 24'h00FF01, 0, 8'h00, 8'hFF};
        vecs[11] = '{1'b1, 24'h00FF01, 1, 8'hFF, 8'h00};
        vecs[12] = '{1'b1, 24'h00FF01, 2, 8'h01, 8'h01};
        vecs[13] = '{1'b1, 24'h00FF01, 3, 8'h01, 8'h01};
        vecs[14] = '{1'b1, 24'h00FF01, 4, 8'h02, 8'h02};
        vecs[15] = '{1'b1, 24'h00FF01, 5, 8'h02, 8'h02};

        repeat (3) @(negedge clk);
        check("reset_addr_a", 32'(addr_a), 32'd0);
        check("reset_wdata_a", 32'(wd_a), 32'd0);
        check("reset_wren_a", 32'(wren_a), 32'd0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_fin_a", 32'(fin_a), 32'd0);
        check("reset_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;

        for (int t = 0; t < 16; t++) begin
            if (t == 0 || vecs[t].key != vecs[t-1].key || vecs[t].s != vecs[t-1].s) begin
                init_mem(vecs[t].s);
                run(vecs[t].s, vecs[t].key, 0, 0);
            end
            check($sformatf("vec%0d_write", t),
                  (vecs[t].widx < wlog.size()) ? {16'd0, wlog[vecs[t].widx].a, wlog[vecs[t].widx].d} : 32'hFFFF_FFFF,
                  {16'd0, vecs[t].a, vecs[t].d});
        end

        // Reference run, then the same key with start/key disturbed mid-run.
        init_mem(1'b0);
        run(1'b0, 24'h000249, 0, 0);
        prev_mem = final_mem;
        init_mem(1'b0);
        run(1'b0, 24'h000249, 1, 0);
        errs = 0;
        for (int m = 0; m < 256; m++) if (final_mem[m] !== prev_mem[m]) errs++;
        check("disturbed_vs_clean", errs, 0);

        init_mem(1'b0);
        run(1'b0, 24'h000249, 2, 0);

        // Reset mid-run, then a full run from the partly shuffled memory.
        init_mem(1'b0);
        run(1'b0, 24'h000000, 0, 700);
        run(1'b0, 24'h000000, 0, 0);

        for (int r = 0; r < 4; r++) begin
            bit s;
            s = (r >= 2);
            init_mem(s);
            run(s, s ? {8'd0, 16'($urandom)} : 24'($urandom), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
